// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between a byte producer (master) and uart_tx_fifo (slave).
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_tx through its start/ready handshake.
// Optional macro UART_TX_FIFO_NUL_DROP_EN: accept but discard 0x00 words.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_fifo_if.slave         wr,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);
    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH_LOG2'(0) + (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  overflow_q, overflow_d;

    logic is_nul, accept, store, pop;

`ifdef UART_TX_FIFO_NUL_DROP_EN
    assign is_nul = (wr.wr_data == '0);
`else
    assign is_nul = 1'b0;
`endif

    assign empty       = (level_q == '0);
    assign full        = (level_q == FULL_LVL);
    assign wr.wr_ready = !full;
    assign accept      = wr.wr_valid && !full;
    assign store       = accept && !is_nul;

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && tx_ready) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem[rd_ptr_q];
                    state_d    = WAIT_BUSY;
                end
            end
            // uart_tx lowers ready one cycle after start; wait for that before watching for idle
            WAIT_BUSY: if (!tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (tx_ready)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(store);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
        overflow_d = wr.wr_valid && full && !is_nul;
        level_d    = level_q;
        unique case ({store, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q] <= wr.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign level    = level_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; tx_ready is driven as a minimal uart_tx model.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [4:0] level;
    logic       empty, full, overflow;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_if #(.DATA_WIDTH(8)) wif ();

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wif.slave),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        wif.wr_valid = 1'b1;
        wif.wr_data  = d;
        step();
        wif.wr_valid = 1'b0;
    endtask

    // Wait (bounded) for a launch, check its byte, then play one uart_tx busy period.
    task automatic expect_frame(input string tag, input logic [7:0] exp);
        bit seen = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b0;
        step();
        check({tag, "_pulse1"}, 32'(tx_start), 32'd0);
        tx_ready = 1'b1;
        step();
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int starts = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (tx_start !== 1'b0) starts++;
        end
        check(tag, 32'(starts), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        wif.wr_valid = 1'b0;
        wif.wr_data  = 8'h00;
        tx_ready     = 1'b1;
        #12;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wif.wr_ready), 32'd1);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        // Single byte: written at E0, launched at E1
        write_word(8'h48);
        check("single_level_e0", 32'(level), 32'd1);
        check("single_start_e0", 32'(tx_start), 32'd0);
        step();
        check("single_start_e1", 32'(tx_start), 32'd1);
        check("single_data_e1", 32'(tx_data), 32'h48);
        check("single_level_e1", 32'(level), 32'd0);
        tx_ready = 1'b0;
        step();
        check("single_start_e2", 32'(tx_start), 32'd0);
        check("single_data_hold", 32'(tx_data), 32'h48);
        step();
        step();
        check("single_data_hold2", 32'(tx_data), 32'h48);
        tx_ready = 1'b1;
        step();
        expect_quiet("single_no_restart", 4);

        // Fill to full with the transmitter busy, then overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) write_word(8'(i));
        check("fill_level", 32'(level), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_wr_ready", 32'(wif.wr_ready), 32'd0);
        check("fill_overflow", 32'(overflow), 32'd0);
        write_word(8'h11);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        step();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Write while full with a simultaneous pop: dropped on pre-edge level
        tx_ready     = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_data  = 8'h77;
        step();
        wif.wr_valid = 1'b0;
        check("fullpop_start", 32'(tx_start), 32'd1);
        check("fullpop_data", 32'(tx_data), 32'h01);
        check("fullpop_level", 32'(level), 32'd15);
        check("fullpop_overflow", 32'(overflow), 32'd1);
        tx_ready = 1'b0;
        step();
        tx_ready = 1'b1;
        step();
        for (int i = 2; i <= 16; i++) expect_frame($sformatf("drain%0d", i), 8'(i));
        check("drain_level", 32'(level), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        expect_quiet("drain_no_extra", 5);

        // Simultaneous write and pop at level 1
        tx_ready = 1'b0;
        write_word(8'hA1);
        check("simul_level_pre", 32'(level), 32'd1);
        tx_ready     = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_data  = 8'hA2;
        step();
        wif.wr_valid = 1'b0;
        check("simul_start", 32'(tx_start), 32'd1);
        check("simul_data", 32'(tx_data), 32'hA1);
        check("simul_level", 32'(level), 32'd1);
        tx_ready = 1'b0;
        step();
        tx_ready = 1'b1;
        step();
        expect_frame("simul_second", 8'hA2);
        check("simul_level_end", 32'(level), 32'd0);

        // NUL handling
        tx_ready = 1'b0;
        write_word(8'h41);
        write_word(8'h00);
        check("nul_overflow", 32'(overflow), 32'd0);
        write_word(8'h42);
`ifdef UART_TX_FIFO_NUL_DROP_EN
        check("nul_level", 32'(level), 32'd2);
        expect_frame("nul_f0", 8'h41);
        expect_frame("nul_f1", 8'h42);
`else
        check("nul_level", 32'(level), 32'd3);
        expect_frame("nul_f0", 8'h41);
        expect_frame("nul_f1", 8'h00);
        expect_frame("nul_f2", 8'h42);
`endif
        expect_quiet("nul_no_extra", 4);

        // Reset while in WAIT_DONE with five words stored
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) write_word(8'hC0 + 8'(i));
        tx_ready = 1'b1;
        step();
        check("mid_start", 32'(tx_start), 32'd1);
        tx_ready = 1'b0;
        step();
        check("mid_level", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        step();
        rst_n = 1'b1;
        expect_quiet("arst_no_start", 6);
        check("arst_level_after", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
